// File: rtl/seq_bin2bcd_if.sv
// Handshake bundle between a score/distance counter and the sequential BCD converter.
// The master drives start/bin; the slave (converter) returns busy/done/bcd/blank.
interface seq_bin2bcd_if #(
  parameter int W      = 14,
  parameter int DIGITS = 5
);
  logic                  start;
  logic [W-1:0]          bin;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;
  logic [DIGITS-1:0]     blank;

  modport master (
    output start,
    output bin,
    input  busy,
    input  done,
    input  bcd,
    input  blank
  );

  modport slave (
    input  start,
    input  bin,
    output busy,
    output done,
    output bcd,
    output blank
  );
endinterface

// File: rtl/seq_bin2bcd.sv
// Multi-cycle shift-and-add-3 binary-to-BCD converter with one add-3 stage per digit.
// Optional leading-zero blank mask is enabled by defining SEQ_BIN2BCD_BLANK_EN.
module seq_bin2bcd #(
  parameter int W      = 14,
  parameter int DIGITS = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  seq_bin2bcd_if.slave  bus
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(W + 1);

  function automatic bit digitsSufficient();
    longint unsigned pow    = 1;
    longint unsigned maxBin = (longint'(1) << W) - 1;
    for (int i = 0; i < DIGITS; i++) begin
      pow = pow * 10;
    end
    return pow > maxBin;
  endfunction

  localparam bit DIGITS_OK = digitsSufficient();

  if (W < 4) begin : g_badWidth
    $error("seq_bin2bcd: W must be at least 4");
  end
  if (!DIGITS_OK) begin : g_badDigits
    $error("seq_bin2bcd: DIGITS too small to hold 2**W-1");
  end

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t          r_state;
  state_t          w_nextState;
  logic [W-1:0]    r_shreg;
  logic [BW-1:0]   r_acc;
  logic [BW-1:0]   r_bcd;
  logic [CW-1:0]   r_cnt;
  logic [BW-1:0]   w_accAdj;
  logic [BW-1:0]   w_accShift;
  logic            w_lastShift;
  logic            w_accept;

  assign w_accept    = bus.start && (r_state != SHIFT);
  assign w_lastShift = (r_cnt == CW'(W - 1));

  // Digits >= 5 become >= 8 so the following shift carries into the next digit.
  always_comb begin
    w_accAdj = r_acc;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_acc[4*i +: 4] >= 4'd5) begin
        w_accAdj[4*i +: 4] = r_acc[4*i +: 4] + 4'd3;
      end
    end
    w_accShift = (w_accAdj << 1) | BW'(r_shreg[W-1]);
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_nextState = SHIFT;
      SHIFT:   if (w_lastShift) w_nextState = DONE;
      DONE:    w_nextState = bus.start ? SHIFT : IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_shreg <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_bcd   <= '0;
    end else begin
      r_state <= w_nextState;
      if (w_accept) begin
        r_shreg <= bus.bin;
        r_acc   <= '0;
        r_cnt   <= '0;
      end else if (r_state == SHIFT) begin
        r_shreg <= r_shreg << 1;
        r_acc   <= w_accShift;
        r_cnt   <= r_cnt + CW'(1);
      end
      // Result is published on the edge entering DONE so it is valid alongside the done pulse.
      if ((r_state == SHIFT) && w_lastShift) begin
        r_bcd <= w_accShift;
      end
    end
  end

`ifdef SEQ_BIN2BCD_BLANK_EN
  logic [DIGITS-1:0] r_blank;
  logic [DIGITS-1:0] w_blank;
  logic              w_seenDigit;

  always_comb begin
    w_blank     = '0;
    w_seenDigit = 1'b0;
    for (int i = DIGITS - 1; i > 0; i--) begin
      if (w_accShift[4*i +: 4] != 4'd0) begin
        w_seenDigit = 1'b1;
      end
      w_blank[i] = !w_seenDigit;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_blank <= '0;
    end else if ((r_state == SHIFT) && w_lastShift) begin
      r_blank <= w_blank;
    end
  end

  assign bus.blank = r_blank;
`else
  assign bus.blank = '0;
`endif

  assign bus.busy = (r_state == SHIFT);
  assign bus.done = (r_state == DONE);
  assign bus.bcd  = r_bcd;

endmodule

// File: tb/tb_seq_bin2bcd.sv
// Randomised self-checking bench for seq_bin2bcd against a decimal-arithmetic reference model.
// Covers the default W=14/DIGITS=5 instance and a wide W=20/DIGITS=7 instance.
module tb_seq_bin2bcd;

  localparam int W   = 14;
  localparam int D   = 5;
  localparam int WW  = 20;
  localparam int WD  = 7;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int nChecks = 0;
  int nFail   = 0;
  logic [63:0] lastBcd = '0;

  seq_bin2bcd_if #(.W(W),  .DIGITS(D))  bus ();
  seq_bin2bcd_if #(.W(WW), .DIGITS(WD)) wbus ();

  seq_bin2bcd #(.W(W), .DIGITS(D)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  seq_bin2bcd #(.W(WW), .DIGITS(WD)) dutWide (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (wbus.slave)
  );

  always #5 clk = ~clk;

  // Decimal digits by repeated division, packed one nibble per digit.
  function automatic logic [63:0] modelBcd(input longint unsigned v, input int digits);
    logic [63:0] r = '0;
    longint unsigned x = v;
    for (int i = 0; i < digits; i++) begin
      r = r | (64'(x % 10) << (4 * i));
      x = x / 10;
    end
    return r;
  endfunction

  // Digit i (i>0) is a leading zero exactly when the value is below 10**i.
  function automatic logic [63:0] modelBlank(input longint unsigned v, input int digits);
    logic [63:0] r = '0;
`ifdef SEQ_BIN2BCD_BLANK_EN
    longint unsigned pow = 1;
    for (int i = 1; i < digits; i++) begin
      pow = pow * 10;
      r[i] = (v < pow);
    end
`else
    r = {56'd0, 8'(v & 0) } & 64'(digits & 0);
`endif
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    nChecks++;
    if (observed !== expected) begin
      nFail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // One conversion on the narrow instance; optional start pulse while busy.
  task automatic applyStimulus(input int value, input bit glitch);
    int cyc;
    int extra;
    @(negedge clk);
    bus.start = 1'b1;
    bus.bin   = W'(value);
    @(negedge clk);
    bus.start = 1'b0;
    bus.bin   = W'($urandom_range(0, (1 << W) - 1));
    cyc = 1;
    while (!bus.done && cyc < W + 5) begin
      if (cyc == 2) begin
        checkOutput("busyEarly", 64'(bus.busy), 64'd1);
        checkOutput("bcdHeldDuringShift", 64'(bus.bcd), lastBcd);
      end
      if (cyc == W) checkOutput("busyLastShift", 64'(bus.busy), 64'd1);
      if (glitch && cyc == 3) begin
        bus.start = 1'b1;
        bus.bin   = W'(7);
      end
      if (glitch && cyc == 4) bus.start = 1'b0;
      @(negedge clk);
      cyc++;
    end
    checkOutput("latency", 64'(cyc), 64'(W + 1));
    checkOutput("bcd", 64'(bus.bcd), modelBcd(longint'(value), D));
    checkOutput("blank", 64'(bus.blank), modelBlank(longint'(value), D));
    checkOutput("busyInDone", 64'(bus.busy), 64'd0);
    lastBcd = modelBcd(longint'(value), D);
    extra = 0;
    repeat (W + 2) begin
      @(negedge clk);
      if (bus.done) extra++;
    end
    checkOutput("singleDone", 64'(extra), 64'd0);
    checkOutput("bcdHeldAfter", 64'(bus.bcd), lastBcd);
  endtask

  initial begin
    int cyc;
    int extra;
    int vals[2];
    bit busyOk;

    bus.start  = 1'b1;
    bus.bin    = W'(123);
    wbus.start = 1'b0;
    wbus.bin   = '0;
    rst_n      = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rstBusy",  64'(bus.busy),  64'd0);
    checkOutput("rstDone",  64'(bus.done),  64'd0);
    checkOutput("rstBcd",   64'(bus.bcd),   64'd0);
    checkOutput("rstBlank", 64'(bus.blank), 64'd0);
    bus.start = 1'b0;
    rst_n     = 1'b1;
    @(negedge clk);
    checkOutput("idleBusy", 64'(bus.busy), 64'd0);

    applyStimulus(0, 1'b0);
    applyStimulus(16383, 1'b0);
    applyStimulus(9999, 1'b0);
    applyStimulus(42, 1'b1);
    applyStimulus(1, 1'b0);
    applyStimulus(10, 1'b0);
    for (int k = 0; k < 8; k++) begin
      applyStimulus(int'($urandom_range(0, (1 << W) - 1)), k[0]);
    end

    // Start held high: back-to-back conversions every W+1 cycles.
    $display("[TB] back-to-back conversions");
    vals[0] = 1234;
    vals[1] = 4321;
    @(negedge clk);
    bus.start = 1'b1;
    bus.bin   = W'(vals[0]);
    for (int k = 0; k < 2; k++) begin
      cyc    = 0;
      busyOk = 1'b1;
      do begin
        @(negedge clk);
        cyc++;
        if (!bus.done && !bus.busy) busyOk = 1'b0;
      end while (!bus.done && cyc < W + 5);
      checkOutput("b2bLatency", 64'(cyc), 64'(W + 1));
      checkOutput("b2bBcd", 64'(bus.bcd), modelBcd(longint'(vals[k]), D));
      checkOutput("b2bBusyInShift", 64'(busyOk), 64'd1);
      checkOutput("b2bBusyInDone", 64'(bus.busy), 64'd0);
      if (k == 0) bus.bin = W'(vals[1]);
    end
    bus.start = 1'b0;
    lastBcd = modelBcd(longint'(vals[1]), D);
    repeat (2) @(negedge clk);

    // Reset in the middle of a conversion aborts it and clears the result.
    $display("[TB] reset mid-conversion");
    bus.start = 1'b1;
    bus.bin   = W'(500);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("abortBusy",  64'(bus.busy),  64'd0);
    checkOutput("abortBcd",   64'(bus.bcd),   64'd0);
    checkOutput("abortBlank", 64'(bus.blank), 64'd0);
    extra = 0;
    repeat (W + 3) begin
      @(negedge clk);
      if (bus.done) extra++;
    end
    checkOutput("abortNoDone", 64'(extra), 64'd0);
    lastBcd = '0;
    applyStimulus(500, 1'b0);

    // Wide instance: full-scale value.
    $display("[TB] wide instance");
    @(negedge clk);
    wbus.start = 1'b1;
    wbus.bin   = WW'(1048575);
    @(negedge clk);
    wbus.start = 1'b0;
    wbus.bin   = '0;
    cyc = 1;
    while (!wbus.done && cyc < WW + 5) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("wideLatency", 64'(cyc), 64'(WW + 1));
    checkOutput("wideBcd", 64'(wbus.bcd), modelBcd(longint'(1048575), WD));
    checkOutput("wideBlank", 64'(wbus.blank), modelBlank(longint'(1048575), WD));

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
